// File: rtl/cmp_collector_if.sv
// Bundle of handshake, comparator and counter signals around cmp_collector.
// The collector plugs in through the slave modport; its environment uses master.
interface cmp_collector_if #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_diff;
    logic             out_valid;
    logic             out_ready;
    logic             out_equal;
    logic [WIDTH-1:0] out_mask;
    logic             clear_counts;
    logic [CNT_W-1:0] eq_count;
    logic [CNT_W-1:0] ne_count;

    modport master (
        output in_valid, in_a, in_b, cmp_diff, out_ready, clear_counts,
        input  in_ready, cmp_a, cmp_b, out_valid, out_equal, out_mask,
               eq_count, ne_count
    );

    modport slave (
        input  in_valid, in_a, in_b, cmp_diff, out_ready, clear_counts,
        output in_ready, cmp_a, cmp_b, out_valid, out_equal, out_mask,
               eq_count, ne_count
    );
endinterface

// File: rtl/cmp_collector.sv
// Sequences operand pairs into the XOR equality comparator, samples its
// difference flag after one settle cycle and returns one result per pair.
module cmp_collector #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           reset,
    cmp_collector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             sample;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] out_mask_reg;
    logic             out_equal_reg;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] ne_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRIVE exists only to give the comparator a full cycle to settle on the new operands.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                state_next = SAMPLE;
            end
            SAMPLE: begin
                sample     = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            mask_reg <= '0;
        end else if (accept) begin
            a_reg    <= bus.in_a;
            b_reg    <= bus.in_b;
            mask_reg <= bus.in_a ^ bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_equal_reg <= 1'b0;
            out_mask_reg  <= '0;
        end else if (sample) begin
            out_equal_reg <= ~bus.cmp_diff;
            out_mask_reg  <= mask_reg;
        end
    end

    // Clear beats a same-edge increment, so the sample coinciding with a clear is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            eq_cnt <= '0;
            ne_cnt <= '0;
        end else if (bus.clear_counts) begin
            eq_cnt <= '0;
            ne_cnt <= '0;
        end else if (sample) begin
            if (!bus.cmp_diff) begin
                if (eq_cnt != CNT_MAX) begin
                    eq_cnt <= eq_cnt + 1'b1;
                end
            end else begin
                if (ne_cnt != CNT_MAX) begin
                    ne_cnt <= ne_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.cmp_a     = a_reg;
    assign bus.cmp_b     = b_reg;
    assign bus.out_equal = out_equal_reg;
    assign bus.out_mask  = out_mask_reg;
    assign bus.eq_count  = eq_cnt;
    assign bus.ne_count  = ne_cnt;
endmodule

// File: tb/tb_cmp_collector.sv
// Self-checking bench for cmp_collector: directed vector table, multi-cycle
// corner sequences and random pairs against a counting reference model.
module tb_cmp_collector;
    localparam int WIDTH = 5;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               hold;
        logic             expEqual;
        logic [WIDTH-1:0] expMask;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   eqModel;
    int   neModel;
    vec_t vecs[6];

    cmp_collector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    cmp_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Behavioural stand-in for the external XOR comparator.
    assign bus.cmp_diff = (bus.cmp_a != bus.cmp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelSample(input logic equal, input bit clr);
        if (clr) begin
            eqModel = 0;
            neModel = 0;
        end else if (equal) begin
            eqModel = (eqModel < CMAX) ? eqModel + 1 : CMAX;
        end else begin
            neModel = (neModel < CMAX) ? neModel + 1 : CMAX;
        end
    endtask

    task automatic waitInReady();
        int n;
        n = 0;
        while (!bus.in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) checkOutput("in_ready_timeout", 0, 1);
    endtask

    // One full pair: accept, optional clear on the SAMPLE edge, hold, out handshake.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int hold, input bit clr,
                                 input logic expEqual, input logic [WIDTH-1:0] expMask);
        int lat;
        bit got;
        @(negedge clk);
        waitInReady();
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = WIDTH'($urandom);
        bus.in_b     = WIDTH'($urandom);
        got = 0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1;
                lat = i;
                break;
            end
            if (clr && i == 1) bus.clear_counts = 1'b1;
        end
        bus.clear_counts = 1'b0;
        if (!got) begin
            checkOutput("out_valid_timeout", 0, 1);
            bus.out_ready = 1'b0;
            return;
        end
        modelSample(expEqual, clr);
        checkOutput("latency", lat, 2);
        checkOutput("out_equal", {31'b0, bus.out_equal}, {31'b0, expEqual});
        checkOutput("out_mask", {27'b0, bus.out_mask}, {27'b0, expMask});
        checkOutput("cmp_ab", {22'b0, bus.cmp_a, bus.cmp_b}, {22'b0, a, b});
        checkOutput("in_ready_busy", {31'b0, bus.in_ready}, 0);
        checkOutput("eq_count", {24'b0, bus.eq_count}, eqModel);
        checkOutput("ne_count", {24'b0, bus.ne_count}, neModel);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_stable",
                        {17'b0, bus.out_valid, bus.in_ready, bus.out_equal, bus.out_mask, bus.cmp_a, bus.cmp_b},
                        {17'b0, 1'b1, 1'b0, expEqual, expMask, a, b});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("after_handshake", {30'b0, bus.out_valid, bus.in_ready}, 32'd1);
        checkOutput("cmp_ab_kept", {22'b0, bus.cmp_a, bus.cmp_b}, {22'b0, a, b});
        bus.out_ready = 1'b0;
    endtask

    // Accept a pair, then reset after waitEdges negedges (1 = DRIVE, 3 = HOLD).
    task automatic abortPair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input int waitEdges, input string name);
        bit sawValid;
        @(negedge clk);
        waitInReady();
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < waitEdges; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        eqModel = 0;
        neModel = 0;
        checkOutput({name, "_idle"},
                    {19'b0, bus.in_ready, bus.out_valid, bus.out_equal, bus.out_mask, bus.cmp_a},
                    {19'b0, 1'b1, 1'b0, 1'b0, 5'b0, 5'b0});
        checkOutput({name, "_cmp_b"}, {27'b0, bus.cmp_b}, 0);
        checkOutput({name, "_counts"}, {16'b0, bus.eq_count, bus.ne_count}, 0);
        sawValid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) sawValid = 1;
        end
        checkOutput({name, "_no_valid"}, {31'b0, sawValid}, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        checks           = 0;
        errors           = 0;
        eqModel          = 0;
        neModel          = 0;
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_a         = '0;
        bus.in_b         = '0;
        bus.out_ready    = 1'b0;
        bus.clear_counts = 1'b0;

        vecs[0] = '{5'b00100, 5'b00100, 0, 1'b1, 5'b00000};
        vecs[1] = '{5'b00010, 5'b00000, 0, 1'b0, 5'b00010};
        vecs[2] = '{5'b00001, 5'b00001, 0, 1'b1, 5'b00000};
        vecs[3] = '{5'b10101, 5'b01010, 5, 1'b0, 5'b11111};
        vecs[4] = '{5'b11111, 5'b11111, 2, 1'b1, 5'b00000};
        vecs[5] = '{5'b10000, 5'b00000, 1, 1'b0, 5'b10000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state",
                    {19'b0, bus.in_ready, bus.out_valid, bus.out_equal, bus.out_mask, bus.cmp_a},
                    {19'b0, 1'b1, 1'b0, 1'b0, 5'b0, 5'b0});
        checkOutput("reset_cmp_b", {27'b0, bus.cmp_b}, 0);
        checkOutput("reset_counts", {16'b0, bus.eq_count, bus.ne_count}, 0);
        reset = 1'b0;

        foreach (vecs[i])
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].hold, 1'b0,
                          vecs[i].expEqual, vecs[i].expMask);

        for (int i = 0; i < 260; i++) begin
            ra = WIDTH'($urandom);
            applyStimulus(ra, ra, 0, 1'b0, 1'b1, 5'b0);
        end
        checkOutput("eq_saturated", {24'b0, bus.eq_count}, CMAX);
        applyStimulus(5'b01100, 5'b01100, 0, 1'b1, 1'b1, 5'b0);
        checkOutput("cleared_counts", {16'b0, bus.eq_count, bus.ne_count}, 0);

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? ra : WIDTH'($urandom);
            applyStimulus(ra, rb, $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
                          (ra == rb), ra ^ rb);
        end

        abortPair(5'b00110, 5'b00110, 1, "reset_drive");
        abortPair(5'b01000, 5'b00001, 3, "reset_hold");
        applyStimulus(5'b00111, 5'b00101, 0, 1'b0, 1'b0, 5'b00010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
